// File: rtl/icache_dm_if.sv
// Fetch-side (datapath <-> cache) and fill-side (cache <-> memory controller) signal bundle.
// The datapath drives dp_master and the memory controller drives mem_slave; the cache takes dp_slave and mem_master.
interface icache_dm_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;

  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport dp_master  (output imemREN, imemaddr, flush, input  ihit, imemload);
  modport dp_slave   (input  imemREN, imemaddr, flush, output ihit, imemload);
  modport mem_master (output iREN, iaddr, input  iwait, iload);
  modport mem_slave  (input  iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped one-word-per-frame I-cache: zero-cycle hit, miss costs the iwait cycles plus 2.
// Fetch side stalls on ihit=0 for the whole fill; define ICACHE_STATS_EN to add hit/miss counters.
module icache_dm #(
  parameter int NSETS = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  icache_dm_if.dp_slave   dp,
  icache_dm_if.mem_master mem
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state;
  logic [NSETS-1:0]   valid;
  logic [TAG_W-1:0]   tags [NSETS];
  logic [31:0]        data [NSETS];
  logic [29:0]        missaddr;
  logic               iren_r;
  logic [31:0]        iaddr_r;

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               hit;
  logic               start_miss;
  logic               fill_done;
  logic               unused_byte_bits;

  assign req_idx          = dp.imemaddr[IDX_W+1:2];
  assign req_tag          = dp.imemaddr[31:IDX_W+2];
  assign fill_idx         = missaddr[IDX_W-1:0];
  assign fill_tag         = missaddr[29:IDX_W];
  assign unused_byte_bits = ^dp.imemaddr[1:0];

  // Hits are only served from IDLE; a pending flush masks them.
  assign hit        = (state == IDLE) && dp.imemREN && !dp.flush &&
                      valid[req_idx] && (tags[req_idx] == req_tag);
  assign start_miss = (state == IDLE) && dp.imemREN && !hit && !dp.flush;
  assign fill_done  = (state == FILL) && !mem.iwait && !dp.flush;

  assign dp.ihit     = hit;
  assign dp.imemload = hit ? data[req_idx] : 32'h0;
  assign mem.iREN    = iren_r;
  assign mem.iaddr   = iaddr_r;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      valid    <= '0;
      missaddr <= '0;
      iren_r   <= 1'b0;
      iaddr_r  <= 32'h0;
    end else if (dp.flush) begin
      state    <= IDLE;
      valid    <= '0;
      iren_r   <= 1'b0;
      iaddr_r  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start_miss) begin
            missaddr <= dp.imemaddr[31:2];
            iren_r   <= 1'b1;
            iaddr_r  <= {dp.imemaddr[31:2], 2'b00};
            state    <= FILL;
          end
        end
        FILL: begin
          // The miss address is latched, so redirects during the fill are ignored.
          if (!mem.iwait) begin
            valid[fill_idx] <= 1'b1;
            iren_r          <= 1'b0;
            iaddr_r         <= 32'h0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= mem.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (hit)        hit_count  <= hit_count + 32'd1;
      if (start_miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm (NSETS=16): miss/hit timing, conflict, redirect, flush and reset.
module tb_icache_dm;
  logic CLK;
  logic nRST;
  int   tests_run;
  int   tests_failed;

  icache_dm_if bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_dm #(.NSETS(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .dp   (bus),
    .mem  (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    nRST         = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0;
    bus.flush    = 1'b0;
    bus.iwait    = 1'b1;
    bus.iload    = 32'h0;

    #2;
    check("rst_ihit",     32'(bus.ihit), 0);
    check("rst_iREN",     32'(bus.iREN), 0);
    check("rst_iaddr",    bus.iaddr,     0);
    check("rst_imemload", bus.imemload,  0);
`ifdef ICACHE_STATS_EN
    check("rst_hit_count",  hit_count,  0);
    check("rst_miss_count", miss_count, 0);
`endif
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // Cold miss on 0x40: three busy cycles then data.
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    #1;
    check("cold_idle_ihit", 32'(bus.ihit), 0);
    check("cold_idle_iREN", 32'(bus.iREN), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        bus.iwait = 1'b0;
        bus.iload = 32'h2001_0005;
      end
      #1;
      check("cold_fill_iREN",  32'(bus.iREN), 1);
      check("cold_fill_iaddr", bus.iaddr,     32'h40);
      check("cold_fill_ihit",  32'(bus.ihit), 0);
      tick();
    end
    bus.iwait = 1'b1;
    #1;
    check("cold_hit_ihit", 32'(bus.ihit), 1);
    check("cold_hit_load", bus.imemload,  32'h2001_0005);
    check("cold_hit_iREN", 32'(bus.iREN), 0);
    tick();

    // Conflict: 0x80 shares index 0 with 0x40.
    bus.imemaddr = 32'h80;
    #1;
    check("conf_80_miss", 32'(bus.ihit), 0);
    tick();
    #1;
    check("conf_80_iaddr", bus.iaddr, 32'h80);
    bus.iwait = 1'b0;
    bus.iload = 32'h3000_0080;
    tick();
    bus.iwait = 1'b1;
    #1;
    check("conf_80_hit",  32'(bus.ihit), 1);
    check("conf_80_load", bus.imemload,  32'h3000_0080);
    tick();
    bus.imemaddr = 32'h40;
    #1;
    check("conf_40_evicted", 32'(bus.ihit), 0);
    tick();
    #1;
    check("conf_40_iaddr", bus.iaddr, 32'h40);
`ifdef ICACHE_STATS_EN
    check("stats_hit_count",  hit_count,  2);
    check("stats_miss_count", miss_count, 3);
`endif
    // Minimum penalty: memory answers in the first fill cycle.
    bus.iwait = 1'b0;
    bus.iload = 32'h2001_0005;
    tick();
    bus.iwait = 1'b1;
    #1;
    check("refill_40_hit",  32'(bus.ihit), 1);
    check("refill_40_load", bus.imemload,  32'h2001_0005);
    tick();

    // No request in IDLE: no hit, no fill.
    bus.imemREN = 1'b0;
    #1;
    check("noreq_ihit", 32'(bus.ihit), 0);
    tick();
    #1;
    check("noreq_iREN", 32'(bus.iREN), 0);

    // Redirect mid-fill.
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h100;
    #1;
    check("redir_100_miss", 32'(bus.ihit), 0);
    tick();
    #1;
    check("redir_fill1_iaddr", bus.iaddr, 32'h100);
    tick();
    bus.imemaddr = 32'h204;
    #1;
    check("redir_fill2_iaddr", bus.iaddr,     32'h100);
    check("redir_fill2_iREN",  32'(bus.iREN), 1);
    check("redir_fill2_ihit",  32'(bus.ihit), 0);
    tick();
    bus.iwait = 1'b0;
    bus.iload = 32'hAAAA_0100;
    #1;
    check("redir_fill3_iaddr", bus.iaddr, 32'h100);
    tick();
    bus.iwait = 1'b1;
    #1;
    check("redir_204_miss", 32'(bus.ihit), 0);
    tick();
    #1;
    check("redir_204_iaddr", bus.iaddr, 32'h204);
    bus.iwait = 1'b0;
    bus.iload = 32'hBBBB_0204;
    tick();
    bus.iwait = 1'b1;
    #1;
    check("redir_204_hit",  32'(bus.ihit), 1);
    check("redir_204_load", bus.imemload,  32'hBBBB_0204);
    tick();
    bus.imemaddr = 32'h100;
    #1;
    check("redir_100_hit",  32'(bus.ihit), 1);
    check("redir_100_load", bus.imemload,  32'hAAAA_0100);
    tick();

    // Flush on the completing fill cycle: word must be discarded.
    bus.imemaddr = 32'h40;
    #1;
    check("flfill_40_miss", 32'(bus.ihit), 0);
    tick();
    bus.iwait = 1'b0;
    bus.iload = 32'hDEAD_BEEF;
    bus.flush = 1'b1;
    #1;
    check("flfill_iREN_during", 32'(bus.iREN), 1);
    tick();
    bus.flush = 1'b0;
    bus.iwait = 1'b1;
    #1;
    check("flfill_iREN_drop", 32'(bus.iREN), 0);
    check("flfill_40_discard", 32'(bus.ihit), 0);
    bus.imemaddr = 32'h100;
    #1;
    check("flfill_100_inval", 32'(bus.ihit), 0);
    bus.imemaddr = 32'h204;
    #1;
    check("flfill_204_inval", 32'(bus.ihit), 0);
    bus.imemaddr = 32'h100;
    tick();
    #1;
    check("flfill_100_iaddr", bus.iaddr, 32'h100);
    bus.iwait = 1'b0;
    bus.iload = 32'hAAAA_0100;
    tick();
    bus.iwait = 1'b1;
    #1;
    check("flfill_100_hit", 32'(bus.ihit), 1);
    tick();

    // Flush in IDLE masks a hit and starts no miss.
    bus.flush = 1'b1;
    #1;
    check("flidle_ihit", 32'(bus.ihit), 0);
    tick();
    bus.flush = 1'b0;
    #1;
    check("flidle_iREN", 32'(bus.iREN), 0);
    check("flidle_100_inval", 32'(bus.ihit), 0);
    tick();
    #1;
    check("flidle_refill_iREN", 32'(bus.iREN), 1);
    bus.iwait = 1'b0;
    bus.iload = 32'h5555_0100;
    tick();
    bus.iwait = 1'b1;
    #1;
    check("flidle_100_hit",  32'(bus.ihit), 1);
    check("flidle_100_load", bus.imemload,  32'h5555_0100);
    tick();

    // Reset in the middle of a fill.
    bus.imemaddr = 32'h204;
    #1;
    check("rstfill_204_miss", 32'(bus.ihit), 0);
    tick();
    #1;
    check("rstfill_iaddr_pre", bus.iaddr, 32'h204);
    nRST = 1'b0;
    #1;
    check("rstfill_iREN",  32'(bus.iREN), 0);
    check("rstfill_iaddr", bus.iaddr,     0);
    check("rstfill_ihit",  32'(bus.ihit), 0);
    nRST = 1'b1;
    #1;
    check("rstfill_204_miss_after", 32'(bus.ihit), 0);
    bus.imemaddr = 32'h100;
    #1;
    check("rstfill_100_inval", 32'(bus.ihit), 0);
    tick();
    #1;
    check("rstfill_new_miss_iaddr", bus.iaddr, 32'h100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, word-per-block instruction cache. It is the cache-side responder of the datapath instruction port: it answers imemREN/imemaddr with ihit/imemload.
- On a miss it acts as initiator toward the memory controller instruction port (iREN/iaddr, iwait/iload).
- Sits between the pipelined datapath fetch stage and the memory arbiter.

Parameters:
- NSETS, 16, number of frames; power of two, minimum 2. IDX_W = log2(NSETS), TAG_W = 30 - IDX_W.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- imemREN  input  1  datapath fetch request
- imemaddr  input  32  fetch byte address; bits [1:0] ignored
- ihit  output  1  imemload valid this cycle
- imemload  output  32  fetched instruction
- flush  input  1  invalidate all frames (halt or self-modifying code)
- iREN  output  1  memory read request
- iaddr  output  32  memory word address, bits [1:0] = 0
- iwait  input  1  memory busy; iload is valid on the cycle iwait=0 while iREN=1
- iload  input  32  memory read data

Behaviour:
- Address split: index = imemaddr[IDX_W+1:2], tag = imemaddr[31:IDX_W+2].
- Storage per frame: valid bit, TAG_W tag, 32-bit data. Registers only, no SRAM macro.
- Reset (async): all valid=0, state=IDLE, miss-address register=0.
- Reset outputs: ihit=0, iREN=0, iaddr=0, imemload=0.
- FSM states: IDLE and FILL.
- IDLE:
  - hit = imemREN & valid[index] & (tag match). ihit=hit combinationally (zero-cycle hit); imemload = data[index] when hit, else 0.
  - iREN=0, iaddr=0.
  - On imemREN & !hit & !flush: latch imemaddr[31:2] into missaddr, go to FILL.
- FILL:
  - ihit=0, imemload=0, iREN=1, iaddr={missaddr,2'b00}.
  - iaddr is held stable for the whole fill, even if imemaddr or imemREN change (e.g. datapath branch redirect).
  - When iwait=0: write data=iload, tag and valid=1 into the frame selected by missaddr; next state IDLE.
  - Miss latency: cycles of iwait=1, plus one completion cycle, plus one cycle to re-present as a hit in IDLE. Minimum miss penalty = 2 cycles.
- Requested address changed during the fill: the fill still completes into the latched frame. In IDLE the new address is looked up fresh (hit or new miss).
- Conflict: a fill overwrites the valid frame at the same index unconditionally.
- flush:
  - Synchronous, highest priority: next cycle all valid=0 and state=IDLE.
  - In FILL, the fill is aborted. The iload word is discarded even if iwait=0 in the same cycle. iREN drops the next cycle.
  - While flush=1 in IDLE: ihit=0 and no miss is started.
- imemREN=0 in IDLE: ihit=0, no state change.
- No write path; the cache is read-only from the datapath side.
- Asynchronous reset mid-fill: fill abandoned, all outputs return to reset values immediately.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], reset to 0.
  - hit_count increments on each IDLE cycle with ihit=1.
  - miss_count increments on each IDLE->FILL transition.
  - Both counters wrap modulo 2^32 and are not cleared by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, imemREN=1, imemaddr=0x0000_0040, iwait=1 for 3 cycles, then 0 with iload=0x2001_0005.
  - iaddr=0x40 and iREN=1 for 4 cycles; ihit=1, imemload=0x2001_0005 on the following cycle.
- Hit: re-request 0x40 after the fill -> ihit=1 the same cycle, iREN stays 0.
- Conflict (NSETS=16): fill 0x40, then request 0x80 (same index 0, different tag) -> miss.
  - After the fill, 0x80 hits and 0x40 misses.
- Redirect mid-fill: miss on 0x100; imemaddr changes to 0x204 in the second FILL cycle.
  - iaddr stays 0x100 until iwait=0.
  - Then 0x204 misses and 0x100 hits.
- Flush: flush=1 during FILL on the same cycle iwait=0 -> frame not written, state IDLE, the previously cached 0x40 now misses.
- Reset mid-fill: nRST low during FILL -> iREN=0 and ihit=0 immediately; after release, a request to the same address misses.
- ICACHE_STATS_EN: run the cold-miss, hit and conflict sequence -> hit_count=2, miss_count=3.
